// File: rtl/endpoint_pck_injector_pkg.sv
// Shared NoC definitions for the endpoint injector: flit type encodings,
// flit width derivation and header field layout.
package endpoint_pck_injector_pkg;

    typedef enum logic [1:0] {
        FLIT_BODY   = 2'b00,
        FLIT_HDR    = 2'b01,
        FLIT_TAIL   = 2'b10,
        FLIT_SINGLE = 2'b11
    } flit_type_t;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } inj_state_t;

    localparam int HDR_FIELD_W = 64;

    function automatic int flit_width(input int v, input int fpay);
        return 2 + v + fpay;
    endfunction

    function automatic int hdr_src_lsb(input int eaw);
        return eaw;
    endfunction

    function automatic int hdr_len_lsb(input int eaw);
        return 2 * eaw;
    endfunction

    function automatic logic [HDR_FIELD_W-1:0] field_mask(input int w);
        logic [HDR_FIELD_W-1:0] one;
        one = 64'd1;
        return (one << w) - one;
    endfunction

    // Header payload: dest | src << EAw | len << 2*EAw, other bits zero.
    function automatic logic [HDR_FIELD_W-1:0] hdr_payload(
        input logic [HDR_FIELD_W-1:0] dest,
        input logic [HDR_FIELD_W-1:0] src,
        input logic [HDR_FIELD_W-1:0] len,
        input int                     eaw,
        input int                     lenw
    );
        return (dest & field_mask(eaw))
             | ((src & field_mask(eaw)) << hdr_src_lsb(eaw))
             | ((len & field_mask(lenw)) << hdr_len_lsb(eaw));
    endfunction

endpackage

// File: rtl/endpoint_pck_injector_if.sv
// Descriptor request channel plus the endpoint flit/credit channel.
interface endpoint_pck_injector_if #(
    parameter int V    = 2,
    parameter int Fpay = 32,
    parameter int EAw  = 4,
    parameter int LENw = 8
);
    import endpoint_pck_injector_pkg::*;

    localparam int VCw = (V > 1) ? $clog2(V) : 1;
    localparam int Fw  = flit_width(V, Fpay);

    logic            req_valid;
    logic            req_ready;
    logic [EAw-1:0]  req_dest;
    logic [VCw-1:0]  req_vc;
    logic [LENw-1:0] req_len;
    logic [Fw-1:0]   flit_out;
    logic            flit_out_wr;
    logic [V-1:0]    credit_in;

    modport master (
        output req_valid, req_dest, req_vc, req_len, credit_in,
        input  req_ready, flit_out, flit_out_wr
    );

    modport slave (
        input  req_valid, req_dest, req_vc, req_len, credit_in,
        output req_ready, flit_out, flit_out_wr
    );

endinterface

// File: rtl/endpoint_pck_injector_credit_counter.sv
// Single-VC credit counter: starts full at B, saturates at B and flags
// any credit returned while already full (sticky until reset).
module injector_credit_counter #(
    parameter int B = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic dec,
    input  logic inc,
    output logic has_credit,
    output logic err
);
    localparam int CW = $clog2(B + 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;

    // Next-count selection from credit return and flit consumption.
    always_comb begin
        cnt_d = cnt_q;
        err_d = err_q;
        case ({inc, dec})
            2'b10: begin
                if (cnt_q == CW'(B)) begin
                    cnt_d = cnt_q;
                    err_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            2'b01: begin
                if (cnt_q != {CW{1'b0}}) begin
                    cnt_d = cnt_q - CW'(1);
                end else begin
                    cnt_d = cnt_q;
                end
            end
            default: cnt_d = cnt_q;
        endcase
    end

    // Counter and error flag registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= CW'(B);
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign has_credit = (cnt_q != {CW{1'b0}});
    assign err        = err_q;

endmodule

// File: rtl/endpoint_pck_injector.sv
// Endpoint packet injector: serialises one descriptor at a time into
// header/body/tail flits under per-VC credit flow control.
module endpoint_pck_injector
    import endpoint_pck_injector_pkg::*;
#(
    parameter int NOC_ID = 0,
    parameter int V      = 2,
    parameter int B      = 4,
    parameter int Fpay   = 32,
    parameter int EAw    = 4,
    parameter int LENw   = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [EAw-1:0]          src_addr,
    endpoint_pck_injector_if.slave  bus,
    output logic                    busy,
    output logic [31:0]             pck_sent,
    output logic                    credit_err
);
    localparam int VCw = (V > 1) ? $clog2(V) : 1;
    localparam int Fw  = flit_width(V, Fpay);

    if (NOC_ID < 0) begin : g_bad_noc_id
        $error("NOC_ID must be non-negative");
    end
    if (Fpay < 2 * EAw + LENw) begin : g_bad_fpay
        $error("Fpay too narrow for the header fields");
    end

    inj_state_t       state_q, state_d;
    logic [EAw-1:0]   dest_q, dest_d;
    logic [VCw-1:0]   vc_q, vc_d;
    logic [LENw-1:0]  len_q, len_d;
    logic [LENw-1:0]  idx_q, idx_d;
    logic [Fw-1:0]    flit_q, flit_d;
    logic             flit_wr_q, flit_wr_d;
    logic [31:0]      pck_q, pck_d;

    logic [V-1:0]     dec_s;
    logic [V-1:0]     has_credit_s;
    logic [V-1:0]     err_s;
    logic             credit_ok_s;
    logic [LENw-1:0]  last_idx_s;
    logic [HDR_FIELD_W-1:0] hdr_s;
    flit_type_t       ftype_s;
    logic [V-1:0]     vc_onehot_s;
    logic [Fpay-1:0]  payload_s;

    // Field assembly for the flit at the current index.
    always_comb begin
        last_idx_s  = len_q - LENw'(1);
        hdr_s       = hdr_payload(64'(dest_q), 64'(src_addr), 64'(len_q), EAw, LENw);
        vc_onehot_s = {V{1'b0}};
        vc_onehot_s[vc_q] = 1'b1;
        credit_ok_s = has_credit_s[vc_q];
        if (len_q == LENw'(1)) begin
            ftype_s = FLIT_SINGLE;
        end else if (idx_q == {LENw{1'b0}}) begin
            ftype_s = FLIT_HDR;
        end else if (idx_q == last_idx_s) begin
            ftype_s = FLIT_TAIL;
        end else begin
            ftype_s = FLIT_BODY;
        end
        if (ftype_s == FLIT_HDR || ftype_s == FLIT_SINGLE) begin
            payload_s = hdr_s[Fpay-1:0];
        end else begin
            payload_s = Fpay'(idx_q);
        end
    end

    // FSM next-state and flit emission.
    always_comb begin
        state_d   = state_q;
        dest_d    = dest_q;
        vc_d      = vc_q;
        len_d     = len_q;
        idx_d     = idx_q;
        flit_d    = flit_q;
        flit_wr_d = 1'b0;
        pck_d     = pck_q;
        dec_s     = {V{1'b0}};
        case (state_q)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    dest_d  = bus.req_dest;
                    vc_d    = bus.req_vc;
                    len_d   = (bus.req_len == {LENw{1'b0}}) ? LENw'(1) : bus.req_len;
                    idx_d   = {LENw{1'b0}};
                    state_d = ST_SEND;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SEND: begin
                if (credit_ok_s) begin
                    flit_wr_d = 1'b1;
                    flit_d    = {ftype_s, vc_onehot_s, payload_s};
                    idx_d     = idx_q + LENw'(1);
                    dec_s     = vc_onehot_s;
                    if (idx_q == last_idx_s) begin
                        state_d = ST_IDLE;
                        pck_d   = pck_q + 32'd1;
                    end else begin
                        state_d = ST_SEND;
                    end
                end else begin
                    flit_wr_d = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, descriptor and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            dest_q    <= {EAw{1'b0}};
            vc_q      <= {VCw{1'b0}};
            len_q     <= LENw'(1);
            idx_q     <= {LENw{1'b0}};
            flit_q    <= {Fw{1'b0}};
            flit_wr_q <= 1'b0;
            pck_q     <= 32'd0;
        end else begin
            state_q   <= state_d;
            dest_q    <= dest_d;
            vc_q      <= vc_d;
            len_q     <= len_d;
            idx_q     <= idx_d;
            flit_q    <= flit_d;
            flit_wr_q <= flit_wr_d;
            pck_q     <= pck_d;
        end
    end

    for (genvar v = 0; v < V; v++) begin : g_credit
        injector_credit_counter #(.B(B)) u_cnt (
            .clk        (clk),
            .reset      (reset),
            .dec        (dec_s[v]),
            .inc        (bus.credit_in[v]),
            .has_credit (has_credit_s[v]),
            .err        (err_s[v])
        );
    end

    assign bus.req_ready   = (state_q == ST_IDLE);
    assign bus.flit_out    = flit_q;
    assign bus.flit_out_wr = flit_wr_q;
    assign busy            = (state_q == ST_SEND);
    assign pck_sent        = pck_q;
    assign credit_err      = |err_s;

endmodule
